// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to req0.
module alu_arbiter #(
    parameter int unsigned SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [2:0]      req0_ctl,
    input  logic [2:0]      req1_ctl,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic [2:0]      alu_ctl,
    output logic [SIZE-1:0] alu_in1,
    output logic [SIZE-1:0] alu_in2,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_carry,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [SIZE-1:0] rsp_data,
    output logic            rsp_carry,
    output logic            rsp_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [2:0]      op_ctl_q;
    logic [SIZE-1:0] op_a_q, op_b_q;
    logic            op_id_q;
    logic            rsp_id_q, rsp_carry_q, rsp_zero_q;
    logic [SIZE-1:0] rsp_data_q;
    logic            gnt0, gnt1, accept, idle_open;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    logic last_grant_q;

    // On a tie the requester that was not granted last wins.
    assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
    assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= req1_ready;
        end
    end
`else
    assign gnt0 = req0_valid;
    assign gnt1 = req1_valid & ~req0_valid;
`endif

    // Grants are withheld while reset is held so nothing is accepted before it falls.
    assign idle_open  = (state_q == IDLE) & ~rst;
    assign req0_ready = idle_open & gnt0;
    assign req1_ready = idle_open & gnt1;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ctl_q <= 3'b111;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_id_q  <= 1'b0;
        end else if (accept) begin
            op_ctl_q <= req1_ready ? req1_ctl : req0_ctl;
            op_a_q   <= req1_ready ? req1_a : req0_a;
            op_b_q   <= req1_ready ? req1_b : req0_b;
            op_id_q  <= req1_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_id_q    <= op_id_q;
            rsp_data_q  <= alu_out;
            rsp_carry_q <= alu_carry;
            rsp_zero_q  <= alu_zero;
        end
    end

    // The shared ALU sees a neutral "zero" op whenever we are not executing.
    always_comb begin
        alu_ctl = 3'b111;
        alu_in1 = '0;
        alu_in2 = '0;
        if (state_q == EXEC) begin
            alu_ctl = op_ctl_q;
            alu_in1 = op_a_q;
            alu_in2 = op_b_q;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic against a
// transaction-level model; the shared ALU is modelled here as a combinational stub.
module tb_alu_arbiter;

    localparam int unsigned SIZE = 10;

    logic            clk, rst;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]      req0_ctl, req1_ctl, alu_ctl;
    logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [SIZE-1:0] alu_in1, alu_in2, alu_out;
    logic            alu_carry, alu_zero;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
    logic [SIZE-1:0] rsp_data;
    logic [SIZE:0]   alu_res;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_ctl(req0_ctl), .req1_ctl(req1_ctl),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctl(alu_ctl), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {carry, data}; shifts and logic ops report carry 0
    function automatic logic [SIZE:0] alu_f(input logic [2:0] c, input logic [SIZE-1:0] x,
                                            input logic [SIZE-1:0] y);
        logic [SIZE:0] r;
        case (c)
            3'b001:  r = {1'b0, x} + {1'b0, y};
            3'b011:  r = {1'b0, x} - {1'b0, y};
            3'b010:  r = {1'b0, x & y};
            3'b101:  r = {1'b0, x | y};
            3'b100:  r = {1'b0, x << 1};
            3'b110:  r = {1'b0, x >> 1};
            3'b000:  r = {1'b0, x};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_res   = alu_f(alu_ctl, alu_in1, alu_in2);
    assign alu_out   = alu_res[SIZE-1:0];
    assign alu_carry = alu_res[SIZE];
    assign alu_zero  = (alu_res[SIZE-1:0] == '0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: one op in flight, age counts edges since its acceptance.
    bit              m_pending = 1'b0;
    int              m_age = 0;
    bit              m_last = 1'b1;
    bit              m_id;
    logic [2:0]      m_ctl;
    logic [SIZE-1:0] m_a, m_b;
    logic [SIZE:0]   m_res;

    int              grants[$];
    logic            obs_rsp_valid, obs_rsp_id, obs_rsp_carry, obs_rsp_zero, obs_acc;
    logic [SIZE-1:0] obs_rsp_data;

    task automatic step();
        bit exp_r0, exp_r1, exp_rsp, exec, win;
        @(negedge clk);
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        win    = 1'b0;
        if (!m_pending && (req0_valid || req1_valid)) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            if (req0_valid && req1_valid) win = ~m_last;
            else win = req1_valid;
`else
            win = !req0_valid;
`endif
            exp_r0 = !win;
            exp_r1 = win;
        end
        exp_rsp = m_pending && (m_age >= 2);
        exec    = m_pending && (m_age == 1);
        check("req0_ready", 32'(req0_ready), 32'(exp_r0));
        check("req1_ready", 32'(req1_ready), 32'(exp_r1));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check("alu_ctl", 32'(alu_ctl), exec ? 32'(m_ctl) : 32'(3'b111));
        check("alu_in1", 32'(alu_in1), exec ? 32'(m_a) : 32'd0);
        check("alu_in2", 32'(alu_in2), exec ? 32'(m_b) : 32'd0);
        if (exp_rsp) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_data", 32'(rsp_data), 32'(m_res[SIZE-1:0]));
            check("rsp_carry", 32'(rsp_carry), 32'(m_res[SIZE]));
            check("rsp_zero", 32'(rsp_zero), 32'(m_res[SIZE-1:0] == '0));
        end
        if (req0_ready) grants.push_back(0);
        if (req1_ready) grants.push_back(1);
        obs_acc       = req0_ready | req1_ready;
        obs_rsp_valid = rsp_valid;
        obs_rsp_id    = rsp_id;
        obs_rsp_data  = rsp_data;
        obs_rsp_carry = rsp_carry;
        obs_rsp_zero  = rsp_zero;
        if (exp_r0 || exp_r1) begin
            m_pending = 1'b1;
            m_age     = 1;
            m_id      = win;
            m_last    = win;
            m_ctl     = win ? req1_ctl : req0_ctl;
            m_a       = win ? req1_a : req0_a;
            m_b       = win ? req1_b : req0_b;
            m_res     = alu_f(m_ctl, m_a, m_b);
        end else if (m_pending) begin
            if (exp_rsp && rsp_ready) m_pending = 1'b0;
            else m_age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input bit id, input logic [2:0] c,
                              input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                              input logic [SIZE-1:0] ed, input bit ec, input bit ez);
        req0_valid = !id;
        req1_valid = id;
        req0_ctl = c; req0_a = a; req0_b = b;
        req1_ctl = c; req1_a = a; req1_b = b;
        rsp_ready = 1'b1;
        step();
        check({tag, "_accept"}, 32'(obs_acc), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '1; req1_a = '1;
        step();
        step();
        check({tag, "_valid"}, 32'(obs_rsp_valid), 32'd1);
        check({tag, "_data"}, 32'(obs_rsp_data), 32'(ed));
        check({tag, "_carry"}, 32'(obs_rsp_carry), 32'(ec));
        check({tag, "_zero"}, 32'(obs_rsp_zero), 32'(ez));
        check({tag, "_id"}, 32'(obs_rsp_id), 32'(id));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_ctl = '0; req1_ctl = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_alu_ctl", 32'(alu_ctl), 32'(3'b111));
        rst = 1'b0;

        // Tie, both valid continuously
        rsp_ready = 1'b1;
        grants.delete();
        repeat (12) step();
        check("tie_count", 32'(grants.size()), 32'd4);
        n = grants.size();
        for (int i = 0; i < n && i < 4; i++) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            check("tie_grant", 32'(grants[i]), 32'(i % 2));
`else
            check("tie_grant", 32'(grants[i]), 32'd0);
`endif
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        run_single("add", 1'b0, 3'b001, 10'h1FF, 10'h001, 10'h200, 1'b0, 1'b0);
        run_single("carry", 1'b1, 3'b001, 10'h3FF, 10'h001, 10'h000, 1'b1, 1'b1);
        run_single("shl", 1'b0, 3'b100, 10'h201, 10'h000, 10'h002, 1'b0, 1'b0);
        run_single("pass", 1'b1, 3'b000, 10'h155, 10'h0AA, 10'h155, 1'b0, 1'b0);

        // Backpressure
        req0_valid = 1'b1; req0_ctl = 3'b101; req0_a = 10'h0F0; req0_b = 10'h00F;
        rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 10'h3C3;
        repeat (5) step();
        rsp_ready = 1'b1;
        step();
        check("bp_handshake", 32'(obs_rsp_valid), 32'd1);
        step();
        check("bp_next_accept", 32'(obs_acc), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) step();

        // Reset during EXEC of sub 5-3
        req0_valid = 1'b1; req0_ctl = 3'b011; req0_a = 10'd5; req0_b = 10'd3;
        step();
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_alu_ctl", 32'(alu_ctl), 32'(3'b111));
        check("mid_rst_data", 32'(rsp_data), 32'd0);
        m_pending = 1'b0;
        m_last = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step();
        run_single("after_rst", 1'b0, 3'b011, 10'd5, 10'd3, 10'd2, 1'b0, 1'b0);

        // Randomized traffic; operands keep changing after acceptance
        repeat (400) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 1) == 1);
            req0_ctl = 3'($urandom); req1_ctl = 3'($urandom);
            req0_a = SIZE'($urandom); req0_b = SIZE'($urandom);
            req1_a = SIZE'($urandom); req1_b = SIZE'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
